layer_sequencer: RTL

LAYER_SEQUENCER -- requirements
Module: layer_sequencer

---
 rtl/nn_pkg.sv | 24 ++
 rtl/seq_watchdog.sv | 28 ++
 rtl/layer_sequencer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// Shared types and constants for the NN layer sequencer and its watchdog.
package nn_pkg;

    localparam int NN_ADDR_W   = 8;
    localparam int DESC_FIELDS = 4;

    // Descriptor word slots, each one ADDR_W bits wide, lowest slot first.
    localparam int FLD_NK     = 0;
    localparam int FLD_WBASE  = 1;
    localparam int FLD_RBASE  = 2;
    localparam int FLD_WRBASE = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_ARM,
        S_RUN,
        S_NEXT,
        S_DONE,
        S_ERR
    } seq_state_t;

endpackage

// File: rtl/seq_watchdog.sv
// Per-layer cycle counter: cleared on RUN entry, counts while enabled,
// flags expiry in the cycle that completes `limit` enabled cycles.
module seq_watchdog #(
    parameter int CNT_W = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic             expired
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign expired = enable && !clear && (r_cnt == limit - 1'b1);

endmodule

// File: rtl/layer_sequencer.sv
// Walks a descriptor table, configuring and running the AddressGenerator once per layer.
// Optional per-layer watchdog compiled in with LAYER_SEQ_WATCHDOG_EN.
module layer_sequencer
    import nn_pkg::*;
#(
    parameter int ADDR_W         = NN_ADDR_W,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          abort,
    input  logic [ADDR_W-1:0]             num_layers,
    input  logic [ADDR_W-1:0]             desc_base,
    output logic [ADDR_W-1:0]             desc_addr,
    input  logic [DESC_FIELDS*ADDR_W-1:0] desc_data,
    output logic                          ag_reset,
    output logic                          ag_run,
    output logic [ADDR_W-1:0]             ag_Nk,
    output logic [ADDR_W-1:0]             ag_read_weight_base_addr,
    output logic [ADDR_W-1:0]             ag_read_neuro_base_addr,
    output logic [ADDR_W-1:0]             ag_write_neuro_base_addr,
    input  logic                          ag_finished,
    output logic                          busy,
    output logic                          done,
    output logic                          error,
    output logic [ADDR_W-1:0]             layer_idx
);

    seq_state_t        r_state, w_next;
    logic [ADDR_W-1:0] r_num_layers, r_layer_idx, r_desc_addr;
    logic [ADDR_W-1:0] r_nk, r_wbase, r_rbase, r_wrbase;
    logic [ADDR_W-1:0] w_idx_inc;
    logic              r_busy, r_done, r_ag_run, r_ag_reset;
    logic              w_launch, w_last, w_expired;

    assign w_idx_inc = r_layer_idx + 1'b1;
    assign w_last    = (w_idx_inc == r_num_layers);
    assign w_launch  = ((r_state == S_IDLE) || (r_state == S_ERR)) && start && !abort;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = (num_layers == '0) ? S_DONE : S_FETCH;
            S_FETCH: w_next = S_LOAD;
            S_LOAD:  w_next = S_ARM;
            S_ARM:   w_next = S_RUN;
            S_RUN: begin
                if (ag_finished)    w_next = S_NEXT;
                else if (w_expired) w_next = S_ERR;
            end
            S_NEXT:  w_next = w_last ? S_DONE : S_FETCH;
            S_DONE:  w_next = S_IDLE;
            S_ERR:   if (start) w_next = (num_layers == '0) ? S_DONE : S_FETCH;
            default: w_next = S_IDLE;
        endcase
        // ERR is only left through start or reset; everywhere else abort forces IDLE.
        if (abort) w_next = (r_state == S_ERR) ? S_ERR : S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_num_layers <= '0;
            r_layer_idx  <= '0;
            r_desc_addr  <= '0;
            r_nk         <= '0;
            r_wbase      <= '0;
            r_rbase      <= '0;
            r_wrbase     <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_ag_run     <= 1'b0;
            r_ag_reset   <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_busy     <= w_next inside {S_FETCH, S_LOAD, S_ARM, S_RUN, S_NEXT};
            r_ag_run   <= (w_next == S_RUN);
            r_ag_reset <= (w_next == S_ARM);
            r_done     <= (r_state == S_DONE) && !abort;
            if (w_launch && (num_layers != '0)) begin
                r_num_layers <= num_layers;
                r_layer_idx  <= '0;
                r_desc_addr  <= desc_base;
            end
            // Memory answered the FETCH address last cycle.
            if ((r_state == S_LOAD) && (w_next == S_ARM)) begin
                r_nk     <= desc_data[FLD_NK*ADDR_W     +: ADDR_W];
                r_wbase  <= desc_data[FLD_WBASE*ADDR_W  +: ADDR_W];
                r_rbase  <= desc_data[FLD_RBASE*ADDR_W  +: ADDR_W];
                r_wrbase <= desc_data[FLD_WRBASE*ADDR_W +: ADDR_W];
            end
            if ((r_state == S_NEXT) && (w_next == S_FETCH)) begin
                r_layer_idx <= w_idx_inc;
                r_desc_addr <= r_desc_addr + 1'b1;
            end
        end
    end

`ifdef LAYER_SEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic r_error;

    seq_watchdog #(.CNT_W(WD_W)) u_wd (
        .clk     (clk),
        .reset   (reset),
        .clear   ((w_next == S_RUN) && (r_state != S_RUN)),
        .enable  (r_state == S_RUN),
        .limit   (WD_W'(TIMEOUT_CYCLES)),
        .expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_error <= 1'b0;
        end else if (w_launch) begin
            r_error <= 1'b0;
        end else if ((r_state == S_RUN) && (w_next == S_ERR)) begin
            r_error <= 1'b1;
        end
    end

    assign error = r_error;
`else
    logic [31:0] w_unused_timeout;

    assign w_unused_timeout = TIMEOUT_CYCLES;
    assign w_expired        = 1'b0;
    assign error            = 1'b0;
`endif

    assign desc_addr                = r_desc_addr;
    assign layer_idx                = r_layer_idx;
    assign ag_Nk                    = r_nk;
    assign ag_read_weight_base_addr = r_wbase;
    assign ag_read_neuro_base_addr  = r_rbase;
    assign ag_write_neuro_base_addr = r_wrbase;
    assign ag_reset                 = r_ag_reset;
    assign ag_run                   = r_ag_run;
    assign busy                     = r_busy;
    assign done                     = r_done;

endmodule
